// File: rtl/id_ex_if.sv
// Signal bundle between decode/write-back and the ID/EX pipeline register.
// The master side drives ID, WB and EX control inputs; the slave side is the stage itself.
interface id_ex_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CTRLW = 8,
    parameter int unsigned CNTW  = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [XLEN-1:0]  id_rd1;
    logic [XLEN-1:0]  id_rd2;
    logic [XLEN-1:0]  id_imm;
    logic [XLEN-1:0]  id_pc;
    logic [CTRLW-1:0] id_ctrl;
    logic             id_mem_read;
    logic             id_reg_write;
    logic [4:0]       wb_ws;
    logic [XLEN-1:0]  wb_wd;
    logic             wb_reg_write;
    logic             ex_hold;
    logic             ex_flush;
    logic             stall_ld;
    logic             ex_valid;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [XLEN-1:0]  ex_op1;
    logic [XLEN-1:0]  ex_op2;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_pc;
    logic [CTRLW-1:0] ex_ctrl;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [CNTW-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc, id_ctrl,
               id_mem_read, id_reg_write, wb_ws, wb_wd, wb_reg_write, ex_hold, ex_flush,
        input  stall_ld, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_pc,
               ex_ctrl, ex_mem_read, ex_reg_write, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc, id_ctrl,
               id_mem_read, id_reg_write, wb_ws, wb_wd, wb_reg_write, ex_hold, ex_flush,
        output stall_ld, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_pc,
               ex_ctrl, ex_mem_read, ex_reg_write, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush/hold handling and a saturating bubble counter.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CTRLW = 8,
    parameter int unsigned CNTW  = 16
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    typedef enum logic {StBubble = 1'b0, StValid = 1'b1} slot_e;

    typedef struct packed {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [CTRLW-1:0] ctrl;
        logic             mem_read;
        logic             reg_write;
    } slot_t;

    slot_e           state_q, state_d;
    slot_t           slot_q, slot_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] op1, op2;
    logic            stall;

    // The register file has no hardwired zero, so index 0 is bypassed too.
    always_comb begin
        op1 = bus.id_rd1;
        op2 = bus.id_rd2;
        if (bus.wb_reg_write && (bus.wb_ws == bus.id_rs1)) op1 = bus.wb_wd;
        if (bus.wb_reg_write && (bus.wb_ws == bus.id_rs2)) op2 = bus.wb_wd;
    end

    assign stall = !bus.ex_flush && (state_q == StValid) && slot_q.mem_read &&
                   slot_q.reg_write && bus.id_valid &&
                   ((slot_q.rd == bus.id_rs1) || (slot_q.rd == bus.id_rs2));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        if (bus.ex_flush) begin
            state_d = StBubble;
            slot_d  = '0;
        end else if (bus.ex_hold) begin
            state_d = state_q;
        end else if (stall) begin
            state_d = StBubble;
            slot_d  = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
        end else begin
            state_d          = bus.id_valid ? StValid : StBubble;
            slot_d.rs1       = bus.id_rs1;
            slot_d.rs2       = bus.id_rs2;
            slot_d.rd        = bus.id_rd;
            slot_d.op1       = op1;
            slot_d.op2       = op2;
            slot_d.imm       = bus.id_imm;
            slot_d.pc        = bus.id_pc;
            slot_d.ctrl      = bus.id_ctrl;
            slot_d.mem_read  = bus.id_mem_read & bus.id_valid;
            slot_d.reg_write = bus.id_reg_write & bus.id_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBubble;
            slot_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_ld     = stall;
    assign bus.ex_valid     = (state_q == StValid);
    assign bus.ex_rs1       = slot_q.rs1;
    assign bus.ex_rs2       = slot_q.rs2;
    assign bus.ex_rd        = slot_q.rd;
    assign bus.ex_op1       = slot_q.op1;
    assign bus.ex_op2       = slot_q.op2;
    assign bus.ex_imm       = slot_q.imm;
    assign bus.ex_pc        = slot_q.pc;
    assign bus.ex_ctrl      = slot_q.ctrl;
    assign bus.ex_mem_read  = slot_q.mem_read;
    assign bus.ex_reg_write = slot_q.reg_write;
    assign bus.bubble_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// compared against a slot-level reference model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    id_ex_if #(.XLEN(32), .CTRLW(8), .CNTW(4)) bus ();

    id_ex_stage #(.XLEN(32), .CTRLW(8), .CNTW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] op1, op2, imm, pc;
        logic [7:0]  ctrl;
        logic        mr, rw;
    } slot_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_imm = 0; bus.id_pc = 0; bus.id_ctrl = 0;
        bus.id_mem_read = 0; bus.id_reg_write = 0;
        bus.wb_ws = 0; bus.wb_wd = 0; bus.wb_reg_write = 0;
        bus.ex_hold = 0; bus.ex_flush = 0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic mr, input logic rw, input logic [31:0] pc);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_mem_read = mr; bus.id_reg_write = rw;
        bus.id_pc = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        n_cmp++;
        if ({bus.ex_valid, bus.stall_ld, bus.bubble_cnt, bus.ex_op1} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset: valid=%b stall=%b cnt=%0d op1=%h, want all 0",
                     bus.ex_valid, bus.stall_ld, bus.bubble_cnt, bus.ex_op1);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        set_id(1, 3, 4, 7, 32'd2, 32'd2, 0, 1, 32'h40);
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'd2 || bus.ex_op2 !== 32'd2 ||
            bus.bubble_cnt !== 4'd0 || bus.ex_rd !== 5'd7) begin
            n_bad++;
            $display("FAIL basic: valid=%b op1=%h op2=%h cnt=%0d rd=%0d, want 1 2 2 0 7",
                     bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.bubble_cnt, bus.ex_rd);
        end
    endtask

    task automatic test_bypass();
        bus.wb_reg_write = 1; bus.wb_ws = 5; bus.wb_wd = 32'hDEADBEEF;
        set_id(1, 5, 5, 9, 32'd7, 32'd8, 0, 1, 32'h44);
        tick();
        n_cmp++;
        if (bus.ex_op1 !== 32'hDEADBEEF || bus.ex_op2 !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL bypass_both: op1=%h op2=%h, want deadbeef", bus.ex_op1, bus.ex_op2);
        end
        bus.wb_reg_write = 0;
        tick();
        n_cmp++;
        if (bus.ex_op1 !== 32'd7 || bus.ex_op2 !== 32'd8) begin
            n_bad++;
            $display("FAIL bypass_off: op1=%h op2=%h, want 7 8", bus.ex_op1, bus.ex_op2);
        end
        bus.wb_reg_write = 1; bus.wb_ws = 0; bus.wb_wd = 32'h1234;
        set_id(1, 0, 3, 9, 32'd7, 32'd8, 0, 1, 32'h48);
        tick();
        n_cmp++;
        if (bus.ex_op1 !== 32'h1234 || bus.ex_op2 !== 32'd8) begin
            n_bad++;
            $display("FAIL bypass_x0: op1=%h op2=%h, want 1234 8", bus.ex_op1, bus.ex_op2);
        end
        bus.wb_reg_write = 0;
    endtask

    task automatic test_load_use();
        set_id(1, 1, 2, 6, 0, 0, 1, 1, 32'h50);
        tick();
        set_id(1, 1, 6, 8, 0, 0, 0, 1, 32'h54);
        #1;
        n_cmp++;
        if (bus.stall_ld !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_detect: stall_ld=%b, want 1", bus.stall_ld);
        end
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.bubble_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL lu_bubble: valid=%b rw=%b cnt=%0d, want 0 0 1",
                     bus.ex_valid, bus.ex_reg_write, bus.bubble_cnt);
        end
        n_cmp++;
        if (bus.stall_ld !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_release: stall_ld=%b, want 0", bus.stall_ld);
        end
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8 || bus.ex_pc !== 32'h54) begin
            n_bad++;
            $display("FAIL lu_capture: valid=%b rd=%0d pc=%h, want 1 8 54",
                     bus.ex_valid, bus.ex_rd, bus.ex_pc);
        end
    endtask

    task automatic test_hold();
        set_id(1, 1, 2, 10, 32'd3, 32'd4, 0, 1, 32'h100);
        tick();
        bus.ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 2, 3, 11, 32'd5 + i, 32'd6, 0, 1, 32'h200 + i);
            tick();
            n_cmp++;
            if (bus.ex_pc !== 32'h100 || bus.ex_rd !== 5'd10 || bus.ex_valid !== 1'b1 ||
                bus.ex_op1 !== 32'd3) begin
                n_bad++;
                $display("FAIL hold_%0d: pc=%h rd=%0d valid=%b op1=%h, want 100 10 1 3",
                         i, bus.ex_pc, bus.ex_rd, bus.ex_valid, bus.ex_op1);
            end
        end
        bus.ex_hold = 0;
        tick();
        n_cmp++;
        if (bus.ex_pc !== 32'h202 || bus.ex_op1 !== 32'd7) begin
            n_bad++;
            $display("FAIL hold_release: pc=%h op1=%h, want 202 7", bus.ex_pc, bus.ex_op1);
        end
    endtask

    task automatic test_priority();
        set_id(1, 0, 0, 6, 0, 0, 1, 1, 32'h300);
        tick();
        set_id(1, 6, 1, 9, 0, 0, 0, 1, 32'h304);
        bus.ex_hold = 1; bus.ex_flush = 1;
        #1;
        n_cmp++;
        if (bus.stall_ld !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stall: stall_ld=%b, want 0", bus.stall_ld);
        end
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.bubble_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL flush_prio: valid=%b mr=%b cnt=%0d, want 0 0 1",
                     bus.ex_valid, bus.ex_mem_read, bus.bubble_cnt);
        end
        bus.ex_hold = 0; bus.ex_flush = 0;
        set_id(1, 0, 0, 6, 0, 0, 1, 1, 32'h308);
        tick();
        set_id(1, 6, 1, 9, 0, 0, 0, 1, 32'h30c);
        bus.ex_hold = 1;
        tick();
        n_cmp++;
        if (bus.stall_ld !== 1'b1 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 ||
            bus.bubble_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL hold_prio: stall=%b valid=%b rd=%0d cnt=%0d, want 1 1 6 1",
                     bus.stall_ld, bus.ex_valid, bus.ex_rd, bus.bubble_cnt);
        end
        bus.ex_hold = 0;
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 4'd2) begin
            n_bad++;
            $display("FAIL hold_then_bubble: valid=%b cnt=%0d, want 0 2",
                     bus.ex_valid, bus.bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        rst = 1; idle(); #1; rst = 0;
        // A self-dependent load held in ID hazards against itself every other cycle.
        set_id(1, 6, 6, 6, 0, 0, 1, 1, 32'h400);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            n_cmp++;
            if (bus.bubble_cnt !== 4'(exp_cnt) || bus.ex_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_%0d: cnt=%0d valid=%b, want %0d 0",
                         i, bus.bubble_cnt, bus.ex_valid, exp_cnt);
            end
            tick();
        end
        rst = 1;
        #1;
        n_cmp++;
        if (bus.bubble_cnt !== 4'd0 || bus.ex_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst: cnt=%0d valid=%b, want 0 0", bus.bubble_cnt, bus.ex_valid);
        end
        rst = 0;
    endtask

    task automatic test_random();
        slot_t m;
        int    cnt;
        logic  exp_stall;
        logic [153:0] exp_v, got_v;
        rst = 1; idle(); #1; rst = 0;
        m = '{default: '0};
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_rs1 = 5'($urandom_range(0, 3));
            bus.id_rs2 = 5'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom_range(0, 3));
            bus.id_rd1 = $urandom; bus.id_rd2 = $urandom;
            bus.id_imm = $urandom; bus.id_pc = $urandom; bus.id_ctrl = 8'($urandom);
            bus.id_mem_read = 1'($urandom_range(0, 1));
            bus.id_reg_write = ($urandom_range(0, 3) != 0);
            bus.wb_reg_write = 1'($urandom_range(0, 1));
            bus.wb_ws = 5'($urandom_range(0, 3));
            bus.wb_wd = $urandom;
            bus.ex_hold = ($urandom_range(0, 4) == 0);
            bus.ex_flush = ($urandom_range(0, 7) == 0);
            #1;
            exp_stall = !bus.ex_flush && m.v && m.mr && m.rw && bus.id_valid &&
                        (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
            n_cmp++;
            if (bus.stall_ld !== exp_stall) begin
                n_bad++;
                $display("FAIL rnd_stall_%0d: stall_ld=%b, want %b", c, bus.stall_ld, exp_stall);
            end
            if (bus.ex_flush) begin
                m = '{default: '0};
            end else if (bus.ex_hold) begin
                m = m;
            end else if (exp_stall) begin
                m = '{default: '0};
                if (cnt < 15) cnt++;
            end else begin
                m.v = bus.id_valid;
                m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
                m.op1 = (bus.wb_reg_write && bus.wb_ws == bus.id_rs1) ? bus.wb_wd : bus.id_rd1;
                m.op2 = (bus.wb_reg_write && bus.wb_ws == bus.id_rs2) ? bus.wb_wd : bus.id_rd2;
                m.imm = bus.id_imm; m.pc = bus.id_pc; m.ctrl = bus.id_ctrl;
                m.mr = bus.id_mem_read && bus.id_valid;
                m.rw = bus.id_reg_write && bus.id_valid;
            end
            tick();
            exp_v = {m.v, m.rs1, m.rs2, m.rd, m.op1, m.op2, m.imm, m.pc, m.ctrl, m.mr, m.rw};
            got_v = {bus.ex_valid, bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_op1, bus.ex_op2,
                     bus.ex_imm, bus.ex_pc, bus.ex_ctrl, bus.ex_mem_read, bus.ex_reg_write};
            n_cmp++;
            if (got_v !== exp_v || bus.bubble_cnt !== 4'(cnt)) begin
                n_bad++;
                $display("FAIL rnd_ex_%0d: slot=%h cnt=%0d, want slot=%h cnt=%0d",
                         c, got_v, bus.bubble_cnt, exp_v, cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_load_use();
        test_hold();
        test_priority();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
